frame_sequencer: RTL

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

---
 rtl/frame_seq_pkg.sv | 58 +++++
 rtl/border_painter.sv | 53 +++++
 rtl/frame_sequencer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/frame_seq_pkg.sv
// -----------------------------------------------------------------------------
// frame_seq_pkg
// Shared definitions for the frame sequencer: host mode encodings, pattern
// indices, 3-bit RGB colour constants and the sequencer FSM state encoding.
// Imported by border_painter and frame_sequencer.
// Build option: FRAME_SEQ_CHECKER_EN (see frame_sequencer) enables the
// checkerboard on pattern index 3; nothing in this package depends on it.
// -----------------------------------------------------------------------------
package frame_seq_pkg;

   // Host-selectable display modes (cfg_mode encoding).
   typedef enum logic [1:0] {
      MODE_SOLID  = 2'd0,
      MODE_BORDER = 2'd1,
      MODE_AUTO   = 2'd2,
      MODE_BLANK  = 2'd3
   } mode_e;

   // Pattern indices reported on the pattern output.
   localparam logic [1:0] PAT_WHITE   = 2'd0;
   localparam logic [1:0] PAT_CYAN    = 2'd1;
   localparam logic [1:0] PAT_BORDER  = 2'd2;
   localparam logic [1:0] PAT_CHECKER = 2'd3;

   // Colours packed as {r, g, b}.
   localparam logic [2:0] RGB_BLACK   = 3'b000;
   localparam logic [2:0] RGB_WHITE   = 3'b111;
   localparam logic [2:0] RGB_CYAN    = 3'b011;
   localparam logic [2:0] RGB_YELLOW  = 3'b110;
   localparam logic [2:0] RGB_MAGENTA = 3'b101;
   localparam logic [2:0] RGB_BLUE    = 3'b001;

   // Border width loaded at reset.
   localparam logic [5:0] BORDER_RESET = 6'd20;

   // Sequencer FSM states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_PEND = 2'd2
   } state_e;

   // Pattern shown once a newly applied mode takes over. AUTO restarts its
   // cycle from white; BLANK keeps whatever index was already displayed.
   function automatic logic [1:0] mode_start_pattern(input mode_e mode,
                                                     input logic [1:0] current);
      logic [1:0] pat;
      pat = current;
      case (mode)
         MODE_SOLID:  pat = PAT_WHITE;
         MODE_BORDER: pat = PAT_BORDER;
         MODE_AUTO:   pat = PAT_WHITE;
         MODE_BLANK:  pat = current;
      endcase
      return pat;
   endfunction

endpackage

// File: rtl/border_painter.sv
// -----------------------------------------------------------------------------
// border_painter
// Purely combinational colour for the border test pattern.
//   Frame of width w around the active area: left band white, top band cyan,
//   right band yellow, bottom band magenta, interior blue (priority in that
//   order). Width 0 paints the whole active area blue.
// Parameters: H, V   active pixels per line / active lines per frame
// Ports:
//   i_xpix   [31:0]  current pixel column
//   i_ypix   [31:0]  current pixel row
//   i_width  [5:0]   border width in pixels
//   o_colour [2:0]   {r,g,b}
// -----------------------------------------------------------------------------
module border_painter
   import frame_seq_pkg::*;
#(
   parameter int H = 640,
   parameter int V = 480
) (
   input  logic [31:0] i_xpix,
   input  logic [31:0] i_ypix,
   input  logic [5:0]  i_width,
   output logic [2:0]  o_colour
);

   localparam logic [31:0] H_LAST = 32'(H - 1);
   localparam logic [31:0] V_LAST = 32'(V - 1);

   logic [31:0] w_width;
   logic [31:0] w_right_lim;
   logic [31:0] w_bottom_lim;

   assign w_width = {26'd0, i_width};

   // Far-edge thresholds; clamp at zero so a width larger than the screen
   // can never wrap around to a huge unsigned limit.
   assign w_right_lim  = (H_LAST >= w_width) ? (H_LAST - w_width) : 32'd0;
   assign w_bottom_lim = (V_LAST >= w_width) ? (V_LAST - w_width) : 32'd0;

   always_comb begin
      o_colour = RGB_BLUE;
      if (i_xpix < w_width) begin
         o_colour = RGB_WHITE;
      end else if (i_ypix < w_width) begin
         o_colour = RGB_CYAN;
      end else if (i_xpix > w_right_lim) begin
         o_colour = RGB_YELLOW;
      end else if (i_ypix > w_bottom_lim) begin
         o_colour = RGB_MAGENTA;
      end
   end

endmodule

// File: rtl/frame_sequencer.sv
// -----------------------------------------------------------------------------
// frame_sequencer
// Test-pattern sequencer for a video timing generator. Counts frames on the
// falling edge of vsync, accepts host configuration requests that take effect
// only on a frame boundary, cycles patterns automatically in AUTO mode and
// produces a registered 1-bit-per-channel pixel colour.
//
// Parameters: H, V (active size), FRAMES_PER_STEP (AUTO dwell, >= 1)
// Ports:
//   clk, rst             pixel clock, asynchronous active-high reset
//   vsync                active-low vertical sync pulse
//   disp_enable          high during active video
//   Xpix, Ypix [31:0]    current pixel position
//   cfg_req              host request (level, held until cfg_ack)
//   cfg_mode [1:0]       0 SOLID, 1 BORDER, 2 AUTO, 3 BLANK
//   cfg_border [5:0]     border width
//   cfg_ack              one-cycle pulse when a request has been applied
//   r, g, b              registered pixel colour
//   pattern [1:0]        displayed pattern index
//   frame_cnt [15:0]     frames since reset (wrapping)
//
// Build option: define FRAME_SEQ_CHECKER_EN to render pattern 3 as a 32-pixel
// checkerboard; otherwise pattern 3 is black and no checker logic exists.
// -----------------------------------------------------------------------------
module frame_sequencer
   import frame_seq_pkg::*;
#(
   parameter int H               = 640,
   parameter int V               = 480,
   parameter int FRAMES_PER_STEP = 60
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vsync,
   input  logic        disp_enable,
   input  logic [31:0] Xpix,
   input  logic [31:0] Ypix,
   input  logic        cfg_req,
   input  logic [1:0]  cfg_mode,
   input  logic [5:0]  cfg_border,
   output logic        cfg_ack,
   output logic        r,
   output logic        g,
   output logic        b,
   output logic [1:0]  pattern,
   output logic [15:0] frame_cnt
);

   localparam logic [31:0] STEP_LAST = 32'(FRAMES_PER_STEP - 1);

   // State and datapath registers
   state_e      r_state;
   logic        r_vsync;
   logic        r_cfg_ack;
   logic [15:0] r_frame_cnt;
   logic [1:0]  r_pattern;
   logic [31:0] r_step;
   mode_e       r_mode;
   logic [5:0]  r_border;
   mode_e       r_shadow_mode;
   logic [5:0]  r_shadow_border;
   logic [2:0]  r_rgb;

   // Combinational signals
   state_e      w_state_next;
   logic        w_boundary;
   logic        w_capture;
   logic        w_apply;
   logic [2:0]  w_border_rgb;
   logic [2:0]  w_checker_rgb;
   logic [2:0]  w_pixel_rgb;
   logic [2:0]  w_rgb_next;

   // Frame boundary: vsync was high last cycle and is low now.
   assign w_boundary = r_vsync & ~vsync;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_capture    = 1'b0;
      w_apply      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_boundary) begin
               w_state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            // The ack guard stops a host that still holds cfg_req during the
            // ack cycle from immediately re-queueing the same request.
            if (cfg_req && !r_cfg_ack) begin
               w_state_next = ST_PEND;
               w_capture    = 1'b1;
            end
         end
         ST_PEND: begin
            if (w_boundary) begin
               w_state_next = ST_RUN;
               w_apply      = 1'b1;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // ----------------------------------------------------------- pixel path
   border_painter #(
      .H (H),
      .V (V)
   ) u_border_painter (
      .i_xpix   (Xpix),
      .i_ypix   (Ypix),
      .i_width  (r_border),
      .o_colour (w_border_rgb)
   );

`ifdef FRAME_SEQ_CHECKER_EN
   // 32x32 checkerboard: white where exactly one of the coordinates has bit 5 set.
   assign w_checker_rgb = (Xpix[5] ^ Ypix[5]) ? RGB_WHITE : RGB_BLACK;
`else
   assign w_checker_rgb = RGB_BLACK;
`endif

   always_comb begin
      w_pixel_rgb = RGB_BLACK;
      case (r_pattern)
         PAT_WHITE:   w_pixel_rgb = RGB_WHITE;
         PAT_CYAN:    w_pixel_rgb = RGB_CYAN;
         PAT_BORDER:  w_pixel_rgb = w_border_rgb;
         PAT_CHECKER: w_pixel_rgb = w_checker_rgb;
      endcase
   end

   // Blank outside active video, before the first frame and in BLANK mode.
   assign w_rgb_next = (disp_enable && (r_state != ST_IDLE) && (r_mode != MODE_BLANK))
                     ? w_pixel_rgb : RGB_BLACK;

   // ------------------------------------------------------------- datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vsync         <= 1'b1;
         r_cfg_ack       <= 1'b0;
         r_frame_cnt     <= 16'd0;
         r_pattern       <= PAT_WHITE;
         r_step          <= 32'd0;
         r_mode          <= MODE_SOLID;
         r_border        <= BORDER_RESET;
         r_shadow_mode   <= MODE_SOLID;
         r_shadow_border <= 6'd0;
         r_rgb           <= RGB_BLACK;
      end else begin
         r_vsync   <= vsync;
         r_cfg_ack <= w_apply;
         r_rgb     <= w_rgb_next;

         if (w_boundary) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
         end

         if (w_capture) begin
            r_shadow_mode   <= mode_e'(cfg_mode);
            r_shadow_border <= cfg_border;
         end

         if (w_apply) begin
            r_mode    <= r_shadow_mode;
            r_border  <= r_shadow_border;
            r_step    <= 32'd0;
            r_pattern <= mode_start_pattern(r_shadow_mode, r_pattern);
         end else if (w_boundary && (r_mode == MODE_AUTO)) begin
            // r_step holds boundaries seen in the current dwell minus one.
            if (r_step >= STEP_LAST) begin
               r_step    <= 32'd0;
               r_pattern <= r_pattern + 2'd1;
            end else begin
               r_step <= r_step + 32'd1;
            end
         end
      end
   end

   assign cfg_ack        = r_cfg_ack;
   assign {r, g, b}      = r_rgb;
   assign pattern        = r_pattern;
   assign frame_cnt      = r_frame_cnt;

endmodule
